output_diff_checker: RTL and testbench
======================================

OUTPUT_DIFF_CHECKER -- requirements
Module: output_diff_checker

Interface
REQ-001 Parameter Y_W, 376, width of each compared DUT output vector.
REQ-002 Parameter NUM_VEC, 22, number of samples per test run.
REQ-003 Parameter CNT_W, 16, width of the sample index and mismatch counters.
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port start  input  1  one-cycle pulse that begins a run.
REQ-007 Port sample_valid  input  1  y_ref/y_dut hold a sample this cycle.
REQ-008 Port y_ref  input  Y_W  output of the reference (behavioural) netlist.
REQ-009 Port y_dut  input  Y_W  output of the synthesized netlist.
REQ-010 Port busy  output  1  high while in RUN.
REQ-011 Port done  output  1  high in DONE.
REQ-012 Port mismatch  output  1  sticky; any sample in this run differed.
REQ-013 Port first_fail_idx  output  CNT_W  sample index of the first differing sample.
REQ-014 Port fail_count  output  CNT_W  number of differing samples, saturating at all-ones.
REQ-015 Port signature  output  32  MISR signature of y_dut samples.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and DONE.
- IDLE->RUN on start.
- RUN->DONE on the cycle the NUM_VEC-th valid sample is accepted.
- DONE->RUN on start.
REQ-017 On the start-accepting edge, the block SHALL clear sample_idx, mismatch, first_fail_idx and fail_count, and SHALL load signature with 32'hFFFF_FFFF.
REQ-018 In RUN, the block SHALL ignore start, and SHALL ignore sample_valid when not in RUN.
REQ-019 Each accepted sample SHALL increment sample_idx by 1; the first sample is index 0.
REQ-020 A sample SHALL differ when y_ref != y_dut on any bit.
- On the first differing sample: mismatch=1 and first_fail_idx=sample_idx.
- On every differing sample: fail_count increments, holding at all-ones.
REQ-021 fold(y_dut) SHALL be the XOR of the 32-bit slices of y_dut zero-extended to a multiple of 32 bits; for Y_W=376 this is 12 slices.
REQ-022 On each accepted sample, signature SHALL update to (sig<<1) ^ (sig[31] ? 32'h04C1_1DB7 : 0) ^ fold(y_dut).
REQ-023 All outputs SHALL be registered, and each sample's effect SHALL be visible the cycle after it is accepted (latency 1).
REQ-024 If start and sample_valid are both high in IDLE/DONE, the block SHALL only start the run; that sample is not counted.
REQ-025 When the last sample is accepted, its compare and signature update SHALL complete on the same edge that enters DONE.
REQ-026 In DONE, all result outputs SHALL hold until the next start or rst.

Reset
REQ-027 While rst is high, state SHALL be IDLE, and busy, done, mismatch, first_fail_idx, fail_count and sample_idx SHALL be 0, with signature = 32'hFFFF_FFFF.
REQ-028 rst SHALL take priority over start and sample_valid, and rst during RUN SHALL abort the run with no partial results kept.

Structure
REQ-029 The state enum, MISR polynomial 32'h04C1_1DB7 and seed 32'hFFFF_FFFF SHALL live in the shared package diff_pkg.
REQ-030 The slice-XOR fold plus MISR update SHALL be one sub-module, misr32_fold, parameterized by Y_W.
REQ-031 The RTL SHALL be synthesizable, with no X-dependent logic.

Verification
REQ-032 Reset and idle: rst 2 cycles, then no start for 5 cycles -> busy=0, done=0, signature=FFFFFFFF.
REQ-033 Zero sample: start, one sample with y_ref=y_dut=0 -> signature=FB3EE249, mismatch=0.
REQ-034 Full clean run: start, 22 samples with y_ref=y_dut (every other cycle valid) -> done after the 22nd sample, fail_count=0, busy=0.
REQ-035 Single-bit fault: run of 22 samples with y_dut[375] flipped at samples 3 and 17 -> mismatch=1, first_fail_idx=3, fail_count=2.
REQ-036 Abort and restart: rst asserted after sample 10, then start and 22 clean samples -> done=1, mismatch=0, fail_count=0.
REQ-037 Start ignored in RUN: start pulsed in RUN at sample 5 -> no counter clear, and done arrives after exactly 22 samples.

Source files
------------

// File: rtl/diff_pkg.sv
`default_nettype none
// ============================================================================
// Module      : diff_pkg
// Description : Shared FSM state type and MISR constants for output_diff_checker.
// Revision    : 1.0 - initial release
// ============================================================================
package diff_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [31:0] c_MISR_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] c_MISR_SEED = 32'hFFFF_FFFF;

endpackage : diff_pkg
`default_nettype wire

// File: rtl/output_diff_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : output_diff_checker_if
// Description : Sample stream and result bundle between a driver and the checker.
// Revision    : 1.0 - initial release
// ============================================================================
interface output_diff_checker_if #(
    parameter int Y_W   = 376,
    parameter int CNT_W = 16
);
    logic               start;
    logic               sample_valid;
    logic [Y_W-1:0]     y_ref;
    logic [Y_W-1:0]     y_dut;
    logic               busy;
    logic               done;
    logic               mismatch;
    logic [CNT_W-1:0]   first_fail_idx;
    logic [CNT_W-1:0]   fail_count;
    logic [31:0]        signature;

    modport master (
        output start, sample_valid, y_ref, y_dut,
        input  busy, done, mismatch, first_fail_idx, fail_count, signature
    );

    modport slave (
        input  start, sample_valid, y_ref, y_dut,
        output busy, done, mismatch, first_fail_idx, fail_count, signature
    );
endinterface : output_diff_checker_if
`default_nettype wire

// File: rtl/misr32_fold.sv
`default_nettype none
// ============================================================================
// Module      : misr32_fold
// Description : Folds a Y_W-bit word into 32 bits by slice XOR and advances a MISR.
// Revision    : 1.0 - initial release
// ============================================================================
module misr32_fold
    import diff_pkg::*;
#(
    parameter int Y_W = 376
) (
    input  wire [31:0]      i_sig,
    input  wire [Y_W-1:0]   i_data,
    output logic [31:0]     o_sig
);
    localparam int c_NSLICE = (Y_W + 31) / 32;

    logic [c_NSLICE*32-1:0] w_pad;
    logic [31:0]            w_fold;

    always_comb begin
        w_pad = '0;
        w_pad[Y_W-1:0] = i_data;
        w_fold = '0;
        for (int i = 0; i < c_NSLICE; i++) begin
            w_fold = w_fold ^ w_pad[32*i +: 32];
        end
    end

    assign o_sig = {i_sig[30:0], 1'b0} ^ (i_sig[31] ? c_MISR_POLY : 32'h0) ^ w_fold;

endmodule : misr32_fold
`default_nettype wire

// File: rtl/output_diff_checker.sv
`default_nettype none
// ============================================================================
// Module      : output_diff_checker
// Description : Compares reference and synthesized netlist outputs over a run of
//               NUM_VEC samples, reporting mismatches and a MISR signature.
// Revision    : 1.0 - initial release
// ============================================================================
module output_diff_checker
    import diff_pkg::*;
#(
    parameter int Y_W     = 376,
    parameter int NUM_VEC = 22,
    parameter int CNT_W   = 16
) (
    input  wire                     clk,
    input  wire                     rst,
    output_diff_checker_if.slave    bus
);
    localparam logic [CNT_W-1:0] c_LAST_IDX = CNT_W'(NUM_VEC - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_sample_idx;
    logic               r_busy;
    logic               r_done;
    logic               r_mismatch;
    logic [CNT_W-1:0]   r_first_fail_idx;
    logic [CNT_W-1:0]   r_fail_count;
    logic [31:0]        r_signature;

    logic               w_differ;
    logic [31:0]        w_sig_next;

    assign w_differ = (bus.y_ref != bus.y_dut);

    misr32_fold #(
        .Y_W    (Y_W)
    ) u_misr (
        .i_sig  (r_signature),
        .i_data (bus.y_dut),
        .o_sig  (w_sig_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_sample_idx     <= '0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_mismatch       <= 1'b0;
            r_first_fail_idx <= '0;
            r_fail_count     <= '0;
            r_signature      <= c_MISR_SEED;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    // A sample arriving with start belongs to no run and is dropped.
                    if (bus.start) begin
                        r_state          <= ST_RUN;
                        r_sample_idx     <= '0;
                        r_busy           <= 1'b1;
                        r_done           <= 1'b0;
                        r_mismatch       <= 1'b0;
                        r_first_fail_idx <= '0;
                        r_fail_count     <= '0;
                        r_signature      <= c_MISR_SEED;
                    end
                end
                ST_RUN: begin
                    if (bus.sample_valid) begin
                        r_sample_idx <= r_sample_idx + CNT_W'(1);
                        r_signature  <= w_sig_next;
                        if (w_differ) begin
                            if (!r_mismatch) begin
                                r_mismatch       <= 1'b1;
                                r_first_fail_idx <= r_sample_idx;
                            end
                            if (r_fail_count != '1) begin
                                r_fail_count <= r_fail_count + CNT_W'(1);
                            end
                        end
                        if (r_sample_idx == c_LAST_IDX) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.mismatch       = r_mismatch;
    assign bus.first_fail_idx = r_first_fail_idx;
    assign bus.fail_count     = r_fail_count;
    assign bus.signature      = r_signature;

endmodule : output_diff_checker
`default_nettype wire

// File: tb/tb_output_diff_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_output_diff_checker
// Description : Self-checking bench for output_diff_checker with a run-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_output_diff_checker;
    localparam int Y_W     = 376;
    localparam int NUM_VEC = 22;
    localparam int CNT_W   = 16;

    logic clk;
    logic rst;

    output_diff_checker_if #(.Y_W(Y_W), .CNT_W(CNT_W)) bus ();

    output_diff_checker #(
        .Y_W     (Y_W),
        .NUM_VEC (NUM_VEC),
        .CNT_W   (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: what a run should have produced so far.
    logic        m_run;
    logic        m_done;
    int          m_n;
    logic        m_mis;
    int          m_ffi;
    int          m_cnt;
    logic [31:0] m_sig;

    typedef struct {
        int         f1;
        int         f2;
        int         gap;
        logic       exp_mis;
        int         exp_ffi;
        int         exp_cnt;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] fold(input logic [Y_W-1:0] v);
        logic [383:0] p;
        logic [31:0]  f;
        p = '0;
        p[Y_W-1:0] = v;
        f = 32'h0;
        for (int i = 0; i < 12; i++) f = f ^ 32'(p >> (32 * i));
        return f;
    endfunction

    function automatic logic [Y_W-1:0] rvec();
        logic [383:0] p;
        for (int i = 0; i < 12; i++) p[32*i +: 32] = $urandom;
        return p[Y_W-1:0];
    endfunction

    task automatic model_clear();
        m_n = 0; m_mis = 1'b0; m_ffi = 0; m_cnt = 0; m_sig = 32'hFFFF_FFFF;
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".busy"},      32'(bus.busy),           32'(m_run));
        chk({ctx, ".done"},      32'(bus.done),           32'(m_done));
        chk({ctx, ".mismatch"},  32'(bus.mismatch),       32'(m_mis));
        chk({ctx, ".ffi"},       32'(bus.first_fail_idx), 32'(m_ffi));
        chk({ctx, ".fail_cnt"},  32'(bus.fail_count),     32'(m_cnt));
        chk({ctx, ".signature"}, bus.signature,           m_sig);
    endtask

    task automatic step(input logic st, input logic v,
                        input logic [Y_W-1:0] r, input logic [Y_W-1:0] d);
        bus.start = st; bus.sample_valid = v; bus.y_ref = r; bus.y_dut = d;
        @(posedge clk); #1;
        if (st && !m_run) begin
            model_clear();
            m_run = 1'b1; m_done = 1'b0;
        end else if (v && m_run) begin
            if (r != d) begin
                if (!m_mis) begin m_mis = 1'b1; m_ffi = m_n; end
                m_cnt++;
            end
            m_sig = {m_sig[30:0], 1'b0} ^ (m_sig[31] ? 32'h04C1_1DB7 : 32'h0) ^ fold(d);
            m_n++;
            if (m_n == NUM_VEC) begin m_run = 1'b0; m_done = 1'b1; end
        end
        bus.start = 1'b0; bus.sample_valid = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            step(1'b1, 1'b1, rvec(), rvec());
            m_run = 1'b0; m_done = 1'b0; model_clear();
            check_all("in_reset");
        end
        rst = 1'b0;
    endtask

    // Clean samples except a y_dut[375] flip at sample indices f1/f2.
    task automatic clean_samples(input int count, input int f1, input int f2, input int gap);
        logic [Y_W-1:0] r, d;
        for (int i = 0; i < count; i++) begin
            for (int g = 0; g < gap; g++) step(1'b0, 1'b0, rvec(), rvec());
            r = rvec(); d = r;
            if (i == f1 || i == f2) d[Y_W-1] = ~d[Y_W-1];
            step(1'b0, 1'b1, r, d);
            check_all("sample");
        end
    endtask

    initial begin
        logic [Y_W-1:0] r, d;
        rst = 1'b0;
        bus.start = 1'b0; bus.sample_valid = 1'b0; bus.y_ref = '0; bus.y_dut = '0;
        m_run = 1'b0; m_done = 1'b0; model_clear();

        tbl[0] = '{f1: -1, f2: -1, gap: 1, exp_mis: 1'b0, exp_ffi: 0,  exp_cnt: 0};
        tbl[1] = '{f1: 3,  f2: 17, gap: 0, exp_mis: 1'b1, exp_ffi: 3,  exp_cnt: 2};
        tbl[2] = '{f1: 0,  f2: 21, gap: 2, exp_mis: 1'b1, exp_ffi: 0,  exp_cnt: 2};
        tbl[3] = '{f1: 21, f2: -1, gap: 0, exp_mis: 1'b1, exp_ffi: 21, exp_cnt: 1};
        tbl[4] = '{f1: -1, f2: -1, gap: 0, exp_mis: 1'b0, exp_ffi: 0,  exp_cnt: 0};

        // Reset then idle
        do_reset(2);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, rvec(), rvec());
        chk("idle.busy", 32'(bus.busy), 32'd0);
        chk("idle.done", 32'(bus.done), 32'd0);
        chk("idle.signature", bus.signature, 32'hFFFF_FFFF);

        // Zero sample
        step(1'b1, 1'b0, '0, '0);
        step(1'b0, 1'b1, '0, '0);
        chk("zero.signature", bus.signature, 32'hFB3E_E249);
        chk("zero.mismatch", 32'(bus.mismatch), 32'd0);
        check_all("zero");
        do_reset(1);

        // Table-driven full runs
        foreach (tbl[k]) begin
            step(1'b1, 1'b0, '0, '0);
            check_all("tbl.start");
            clean_samples(NUM_VEC, tbl[k].f1, tbl[k].f2, tbl[k].gap);
            chk("tbl.done", 32'(bus.done), 32'd1);
            chk("tbl.busy", 32'(bus.busy), 32'd0);
            chk("tbl.mismatch", 32'(bus.mismatch), 32'(tbl[k].exp_mis));
            chk("tbl.first_fail_idx", 32'(bus.first_fail_idx), 32'(tbl[k].exp_ffi));
            chk("tbl.fail_count", 32'(bus.fail_count), 32'(tbl[k].exp_cnt));
            // Results hold in DONE regardless of further samples
            for (int i = 0; i < 3; i++) step(1'b0, 1'b1, rvec(), rvec());
            check_all("done_hold");
        end

        // Abort and restart
        step(1'b1, 1'b0, '0, '0);
        clean_samples(11, 4, -1, 0);
        do_reset(1);
        step(1'b1, 1'b0, '0, '0);
        clean_samples(NUM_VEC, -1, -1, 0);
        chk("restart.done", 32'(bus.done), 32'd1);
        chk("restart.mismatch", 32'(bus.mismatch), 32'd0);
        chk("restart.fail_count", 32'(bus.fail_count), 32'd0);

        // Start ignored in RUN: fault at 2 must survive a start pulse at sample 5
        step(1'b1, 1'b0, '0, '0);
        clean_samples(5, 2, -1, 0);
        r = rvec();
        step(1'b1, 1'b1, r, r);
        check_all("start_in_run");
        clean_samples(NUM_VEC - 7, -1, -1, 0);
        chk("sir.busy_before_last", 32'(bus.busy), 32'd1);
        clean_samples(1, -1, -1, 0);
        chk("sir.done", 32'(bus.done), 32'd1);
        chk("sir.first_fail_idx", 32'(bus.first_fail_idx), 32'd2);
        chk("sir.fail_count", 32'(bus.fail_count), 32'd1);

        // Start together with a valid sample from DONE: that sample is dropped
        r = rvec(); d = r; d[0] = ~d[0];
        step(1'b1, 1'b1, r, d);
        chk("sv.mismatch", 32'(bus.mismatch), 32'd0);
        chk("sv.signature", bus.signature, 32'hFFFF_FFFF);
        check_all("start_valid");
        do_reset(1);

        // Randomized runs against the model
        for (int run = 0; run < 8; run++) begin
            step(1'b1, 1'b0, '0, '0);
            for (int c = 0; c < 120 && m_run; c++) begin
                r = rvec(); d = r;
                if ($urandom_range(3) == 0) d[$urandom_range(Y_W-1)] ^= 1'b1;
                if ($urandom_range(7) == 0) d = rvec();
                step(($urandom_range(9) == 0), ($urandom_range(2) != 0), r, d);
                check_all("rand");
            end
            chk("rand.done", 32'(bus.done), 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_output_diff_checker
`default_nettype wire
